// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared loader state encoding, CRC-16-CCITT constants and counter sizing helper
package fpga_cfg_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
    ST_VERIFY,
    ST_FINISH
  } cfg_state_t;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/cfg_crc16.sv
// cfg_crc16: bit-serial CRC-16-CCITT; clear (to CRC_INIT) beats en, bit_in folded MSB-first, crc is the running value
module cfg_crc16
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  logic        fb;
  always_comb begin
    fb    = crc_q[15] ^ bit_in;
    crc_d = clear ? CRC_INIT : en ? ({crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000)) : crc_q;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: host words -> serial config chain (config_en/config_data), optional recirculate+CRC verify, fabric enable/reset release
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_en,
  output logic              config_data,
  input  logic              config_data_ret,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fabric_en,
  output logic              fabric_nrst
);
  localparam int CW = cnt_w(CHAIN_LEN);
  localparam int SW = cnt_w(WORD_W);
  localparam int AW = (CW > SW ? CW : SW) + 1;
  cfg_state_t        state_q, state_d;
  logic              verify_q, verify_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     sent_q, sent_d;
  logic [SW-1:0]     left_q, left_d;
  logic              error_q, error_d;
  logic              fab_q, fab_d;
  logic [AW-1:0]     rem;
  logic              crc_clear, mismatch;
  logic [15:0]       crc_tx, crc_rx;
  always_comb begin
    state_d   = state_q;
    verify_d  = verify_q;
    shreg_d   = shreg_q;
    sent_d    = sent_q;
    left_d    = left_q;
    error_d   = error_q;
    fab_d     = fab_q;
    crc_clear = 1'b0;
    rem       = AW'(CHAIN_LEN) - AW'(sent_q);
    mismatch  = verify_q && (crc_tx != crc_rx);
    case (state_q)
      ST_IDLE:
        if (start) begin
          state_d   = ST_WAIT_WORD;
          verify_d  = verify_en;
          sent_d    = '0;
          error_d   = 1'b0;
          fab_d     = 1'b0;
          crc_clear = 1'b1;
        end
      ST_WAIT_WORD:
        if (word_valid) begin
          shreg_d = word_data;
          left_d  = SW'(rem < AW'(WORD_W) ? rem : AW'(WORD_W));
          state_d = ST_SHIFT;
        end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        sent_d  = sent_q + CW'(1);
        left_d  = left_q - SW'(1);
        if (left_q == SW'(1)) begin
          state_d = sent_q != CW'(CHAIN_LEN - 1) ? ST_WAIT_WORD : verify_q ? ST_VERIFY : ST_FINISH;
          // the bit counter is reused to time the recirculation pass
          if (sent_q == CW'(CHAIN_LEN - 1)) sent_d = '0;
        end
      end
      ST_VERIFY: begin
        sent_d = sent_q + CW'(1);
        if (sent_q == CW'(CHAIN_LEN - 1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        error_d = mismatch;
        fab_d   = !mismatch;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q  <= ST_IDLE;
      verify_q <= 1'b0;
      shreg_q  <= '0;
      sent_q   <= '0;
      left_q   <= '0;
      error_q  <= 1'b0;
      fab_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      verify_q <= verify_d;
      shreg_q  <= shreg_d;
      sent_q   <= sent_d;
      left_q   <= left_d;
      error_q  <= error_d;
      fab_q    <= fab_d;
    end
  cfg_crc16 u_crc_tx (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (crc_clear),
    .en     (state_q == ST_SHIFT),
    .bit_in (shreg_q[WORD_W-1]),
    .crc    (crc_tx)
  );
  cfg_crc16 u_crc_rx (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (crc_clear),
    .en     (state_q == ST_VERIFY),
    .bit_in (config_data_ret),
    .crc    (crc_rx)
  );
  assign word_ready  = state_q == ST_WAIT_WORD;
  assign config_en   = state_q == ST_SHIFT || state_q == ST_VERIFY;
  // during verify the chain output is looped straight back so contents are preserved
  assign config_data = state_q == ST_SHIFT ? shreg_q[WORD_W-1] : state_q == ST_VERIFY ? config_data_ret : 1'b0;
  assign busy        = state_q != ST_IDLE;
  assign done        = state_q == ST_FINISH;
  assign error       = error_q;
  assign fabric_en   = fab_q;
  assign fabric_nrst = fab_q;
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: table-driven and randomized checks of fpga_config_loader against a chain model
module tb_fpga_config_loader;
  localparam int WW = 8;
  localparam int CL = 12;
  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    bit          ver;
    int          flip;
    int          stall;
    bit          mid;
    logic [11:0] tx;
    logic [11:0] chain;
    bit          err;
    int          cyc;
  } vec_t;
  logic clk = 0, nrst = 1, start = 0, verify_en = 0, word_valid = 0;
  logic [WW-1:0] word_data = '0;
  logic word_ready, config_en, config_data, config_data_ret, busy, done, error, fabric_en, fabric_nrst;
  logic [CL-1:0] chain = '0;
  int en_cnt = 0, flip_at = -1, n_cmp = 0, n_fail = 0;
  logic bits[$];
  vec_t tbl[5];
  always #5 clk = ~clk;
  fpga_config_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .clk(clk), .nrst(nrst), .start(start), .verify_en(verify_en),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .config_en(config_en), .config_data(config_data), .config_data_ret(config_data_ret),
    .busy(busy), .done(done), .error(error), .fabric_en(fabric_en), .fabric_nrst(fabric_nrst)
  );
  assign config_data_ret = chain[CL-1] ^ (config_en && en_cnt == flip_at);
  always @(posedge clk)
    if (config_en) begin
      chain  <= {chain[CL-2:0], config_data};
      en_cnt <= en_cnt + 1;
    end
  always @(negedge clk)
    if (config_en) bits.push_back(config_data);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] crc16(input logic [11:0] v);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ v[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
  task automatic run_load(input vec_t v);
    int cyc, hs, dcyc, wait_c, base, nb;
    bit take, pulsed;
    logic [11:0] tx, rx;
    base    = bits.size();
    flip_at = v.flip >= 0 ? en_cnt + CL + v.flip : -1;
    start = 1; verify_en = v.ver; word_valid = 0;
    @(posedge clk); #1;
    start = 0; verify_en = 0;
    chk("busy_ready_after_start", {busy, word_ready}, 2'b11);
    cyc = 1; hs = 0; dcyc = -1; wait_c = 0; pulsed = 0;
    word_data = v.w0; word_valid = 1;
    while (dcyc < 0 && cyc < 100) begin
      take = word_valid && word_ready;
      @(posedge clk); #1;
      cyc++;
      start = 0; verify_en = 0;
      if (take) begin
        hs++; word_valid = 0; wait_c = v.stall; word_data = v.w1;
      end else if (hs < 2 && !word_valid && word_ready) begin
        if (wait_c > 0) wait_c--;
        else word_valid = 1;
      end
      if (v.mid && hs == 1 && !pulsed) begin
        start = 1; verify_en = 1; pulsed = 1;
      end
      if (done) dcyc = cyc;
    end
    word_valid = 0;
    chk("done_seen", dcyc >= 0, 1);
    chk("done_cycle", dcyc, v.cyc);
    chk("handshakes", hs, 2);
    nb = bits.size() - base;
    chk("en_cycles", nb, v.ver ? 24 : 12);
    tx = '0; rx = '0;
    for (int i = 0; i < CL; i++) begin
      if (base + i < bits.size()) tx = {tx[10:0], bits[base+i]};
      if (base + CL + i < bits.size()) rx = {rx[10:0], bits[base+CL+i]};
    end
    chk("tx_bits", tx, v.tx);
    if (v.ver) chk("rx_bits", rx, v.chain);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("error", error, v.err);
    chk("fabric_en", fabric_en, !v.err);
    chk("fabric_nrst", fabric_nrst, !v.err);
    chk("busy_idle", busy, 0);
    chk("chain_contents", chain, v.chain);
  endtask
  initial begin
    tbl[0] = '{8'hA5, 8'h3C, 0, -1, 0, 0, 12'hA53, 12'hA53, 0, 15};
    tbl[1] = '{8'hA5, 8'h3C, 1, -1, 0, 0, 12'hA53, 12'hA53, 0, 27};
    tbl[2] = '{8'hA5, 8'h3C, 1, 3, 0, 0, 12'hA53, 12'hB53, 1, 27};
    tbl[3] = '{8'hA5, 8'h3C, 0, -1, 5, 0, 12'hA53, 12'hA53, 0, 20};
    tbl[4] = '{8'hA5, 8'h3C, 0, -1, 0, 1, 12'hA53, 12'hA53, 0, 15};
    #2 nrst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {word_ready, config_en, config_data, busy, done, error, fabric_en, fabric_nrst}, 8'h00);
    nrst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) run_load(tbl[i]);
    start = 1; word_data = 8'hA5; word_valid = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    word_valid = 0;
    chk("en_at_third_bit", config_en, 1);
    nrst = 0;
    #1;
    chk("reset_mid_shift", {word_ready, config_en, config_data, busy, done, error, fabric_en, fabric_nrst}, 8'h00);
    @(posedge clk); #1;
    nrst = 1;
    @(posedge clk); #1;
    run_load(tbl[0]);
    for (int r = 0; r < 20; r++) begin
      vec_t v;
      logic s[$];
      logic [11:0] rx;
      v.w0    = 8'($urandom);
      v.w1    = 8'($urandom);
      v.ver   = 1'($urandom_range(0, 1));
      v.flip  = (v.ver && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
      v.stall = int'($urandom_range(0, 3));
      v.mid   = 0;
      s.delete();
      for (int b = 7; b >= 0; b--) s.push_back(v.w0[b]);
      for (int b = 7; b >= 0; b--) s.push_back(v.w1[b]);
      v.tx = '0;
      rx   = '0;
      for (int i = 0; i < CL; i++) begin
        v.tx = {v.tx[10:0], s[i]};
        rx   = {rx[10:0], s[i] ^ (i == v.flip)};
      end
      v.err   = v.ver && (crc16(v.tx) != crc16(rx));
      v.chain = v.ver ? rx : v.tx;
      v.cyc   = CL + 2 + 1 + v.stall + (v.ver ? CL : 0);
      run_load(v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion before 500000");
    $fatal(1);
  end
endmodule
